vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster scan generator and pixel output stage for the 1440x900@60 display path.
//  - Drives draw_x/draw_y to the combinational pixel-colour logic.
//  - Registers the returned colour, blanks it outside the active area and drives the VGA pins.
//  - Sync pulses are aligned with the registered colour.
//  - Emits a one-cycle frame_tick at the start of vertical blanking; game logic uses it to
//    update character and food positions.
// PARAMETERS
//  H_ACTIVE  1440  visible pixels per line
//  H_FP      80    horizontal front porch (pixels)
//  H_SYNC    152   hsync pulse width (pixels)
//  H_BP      232   horizontal back porch (pixels); H_TOTAL = 1904
//  V_ACTIVE  900   visible lines per frame
//  V_FP      3     vertical front porch (lines)
//  V_SYNC    6     vsync pulse width (lines)
//  V_BP      25    vertical back porch (lines); V_TOTAL = 934
//  HS_POL    0     hsync active level (0 = active-low)
//  VS_POL    1     vsync active level (1 = active-high)
// PORTS
//  clk          in   1   pixel clock, 106.47 MHz
//  rst_n        in   1   asynchronous active-low reset
//  pix_r        in   4   colour for current draw_x/draw_y, valid the same cycle (combinational)
//  pix_g        in   4   as pix_r
//  pix_b        in   4   as pix_r
//  pat_sel      in   1   test-pattern select; used only when TEST_PATTERN_EN is defined
//  draw_x       out  11  current horizontal count, 0..H_TOTAL-1
//  draw_y       out  10  current vertical count, 0..V_TOTAL-1
//  active       out  1   1 when draw_x<H_ACTIVE and draw_y<V_ACTIVE (same cycle as draw_x/y)
//  frame_tick   out  1   1-cycle pulse when draw_x==0 and draw_y==V_ACTIVE
//  vga_r/g/b    out  4   registered, blanked colour to DAC pins
//  vga_hs       out  1   horizontal sync, registered and aligned with vga_r/g/b
//  vga_vs       out  1   vertical sync, registered and aligned with vga_r/g/b
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous):
//    - draw_x=0, draw_y=0, active=1, frame_tick=0.
//    - vga_r/g/b=0, vga_hs=~HS_POL, vga_vs=~VS_POL.
//    - Counting restarts from (0,0) on the first rising clk after release.
//  - Horizontal counter h:
//    - Increments every clk.
//    - At H_TOTAL-1 it wraps to 0 and v increments.
//  - Vertical counter v:
//    - Wraps to 0 when h wraps and v==V_TOTAL-1.
//    - draw_x and draw_y are the counter registers themselves.
//  - Stage 1 (registered, 1 clk latency from draw_x/draw_y):
//    - vga_r/g/b = active ? pix : 0.
//    - vga_hs = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
//    - vga_vs = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
//    - Both sync decodes use the same-cycle h/v, so every pin output lags draw_x/draw_y by 1 clk.
//  - Sync decodes use full-width compares; no counter value outside its range is reachable.
//  - frame_tick is combinational from the counters and is glitch-free: compare of registered values.
//  - Blanking overrides pixel input: nonzero pix_* during blank never reaches vga_r/g/b.
//  - Line/frame wrap on the same edge (h=H_TOTAL-1, v=V_TOTAL-1): both go to 0 together.
//  - Reset mid-line: outputs go to reset values immediately; no partial sync pulse is extended.
// CONFIGURATION
//  TEST_PATTERN_EN defined:
//    - When pat_sel=1, stage 1 ignores pix_* and outputs 8 vertical colour bars,
//      180 px wide, bar index = draw_x[10:0]/180.
//    - Colour per bar is {r,g,b} = {4{idx[2]},4{idx[1]},4{idx[0]}}.
//    - Blanking still applies.
//  TEST_PATTERN_EN undefined:
//    - pat_sel is ignored; no bar logic is synthesised.
// TESTING
//  T1 reset release -> draw_x/y count 0,1,2..; after 1904 clks draw_x=0, draw_y=1.
//  T2 run one line -> vga_hs low exactly 152 clks, first low cycle 1 clk after draw_x==1520.
//  T3 run full frame (1904*934 clks) -> vga_vs high exactly 6 lines (11424 clks), starting the cycle after draw_y==903,draw_x==0.
//  T4 pix_*=4'hF held constant -> vga_r/g/b=F only for 1440x900 cycles/frame, 0 elsewhere, 1-clk lag.
//  T5 count frame_tick over 3 frames -> exactly 3 pulses, each at draw_x=0, draw_y=900.
//  T6 (TEST_PATTERN_EN, pat_sel=1) -> at draw_x=360 (bar 2) vga_g=F, vga_r=0, vga_b=0 one clk later; assert rst_n mid-frame -> all outputs reset values same cycle.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle for vga_timing_gen: colour request/response plus the VGA pin outputs.
// master = raster generator, slave = pixel-colour logic / board pins.
interface vga_timing_gen_if;
   logic [3:0]  pix_r;
   logic [3:0]  pix_g;
   logic [3:0]  pix_b;
   logic        pat_sel;
   logic [10:0] draw_x;
   logic [9:0]  draw_y;
   logic        active;
   logic        frame_tick;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        vga_hs;
   logic        vga_vs;

   modport master (
      input  pix_r, pix_g, pix_b, pat_sel,
      output draw_x, draw_y, active, frame_tick,
      output vga_r, vga_g, vga_b, vga_hs, vga_vs
   );

   modport slave (
      output pix_r, pix_g, pix_b, pat_sel,
      input  draw_x, draw_y, active, frame_tick,
      input  vga_r, vga_g, vga_b, vga_hs, vga_vs
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 1440x900@60 raster generator with a one-stage registered, blanked pixel/sync output.
// Optional colour-bar source enabled by defining TEST_PATTERN_EN.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 1440,
   parameter int unsigned H_FP     = 80,
   parameter int unsigned H_SYNC   = 152,
   parameter int unsigned H_BP     = 232,
   parameter int unsigned V_ACTIVE = 900,
   parameter int unsigned V_FP     = 3,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 25,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   vga_timing_gen_if.master bus
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

   logic [10:0] h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic        act;
   logic [3:0]  r_q, r_d;
   logic [3:0]  g_q, g_d;
   logic [3:0]  b_q, b_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;

   always_comb begin
      h_d = h_q + 11'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end
   end

   assign act = (h_q < H_ACT) && (v_q < V_ACT);

`ifdef TEST_PATTERN_EN
   logic [2:0] bar;
   assign bar = 3'(h_q / 11'd180);
`else
   logic unused_pat_sel;
   assign unused_pat_sel = bus.pat_sel;
`endif

   // Blanking is applied last so it overrides both the pixel input and the bar source.
   always_comb begin
      r_d = bus.pix_r;
      g_d = bus.pix_g;
      b_d = bus.pix_b;
`ifdef TEST_PATTERN_EN
      if (bus.pat_sel) begin
         r_d = {4{bar[2]}};
         g_d = {4{bar[1]}};
         b_d = {4{bar[0]}};
      end
`endif
      if (!act) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end
      hs_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
      vs_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q  <= '0;
         v_q  <= '0;
         r_q  <= '0;
         g_q  <= '0;
         b_q  <= '0;
         hs_q <= ~HS_POL;
         vs_q <= ~VS_POL;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         r_q  <= r_d;
         g_q  <= g_d;
         b_q  <= b_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
      end
   end

   assign bus.draw_x     = h_q;
   assign bus.draw_y     = v_q;
   assign bus.active     = act;
   assign bus.frame_tick = (h_q == '0) && (v_q == V_ACT);
   assign bus.vga_r      = r_q;
   assign bus.vga_g      = g_q;
   assign bus.vga_b      = b_q;
   assign bus.vga_hs     = hs_q;
   assign bus.vga_vs     = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for horizontal timing, reduced-geometry instance
// (32x18 total, 16x10 active) so vertical sync and frame_tick are reachable quickly.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_gen_if a_if ();
  vga_timing_gen_if b_if ();

  vga_timing_gen u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  vga_timing_gen #(
    .H_ACTIVE (16),
    .H_FP     (4),
    .H_SYNC   (6),
    .H_BP     (6),
    .V_ACTIVE (10),
    .V_FP     (2),
    .V_SYNC   (3),
    .V_BP     (3)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic done   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    if (!done) begin
      $error("FAIL timeout: directed sequence did not complete");
      $finish;
    end
  end

  int ax, ay, pax;
  int bx, by, bpx, bpy;
  logic a_act, pa_act, exp_hs;
  logic b_pact, b_ehs, b_evs, b_eft;
  logic [11:0] pa_pix;
  int mis_a_xy, mis_a_act, mis_a_rgb, mis_a_sync, mis_b;
  int hs_low0, b_vs_hi0, b_vs_first, b_on0, ft_cnt, ft_first;

  initial begin
    mis_a_xy = 0; mis_a_act = 0; mis_a_rgb = 0; mis_a_sync = 0; mis_b = 0;
    hs_low0 = 0; b_vs_hi0 = 0; b_vs_first = 0; b_on0 = 0; ft_cnt = 0; ft_first = 0;
    rst_n = 1'b0;
    {a_if.pix_r, a_if.pix_g, a_if.pix_b} = 12'h000;
    {b_if.pix_r, b_if.pix_g, b_if.pix_b} = 12'hFFF;
    a_if.pat_sel = 1'b0;
    b_if.pat_sel = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_draw_x", a_if.draw_x, 11'd0);
    chk("rst_draw_y", a_if.draw_y, 10'd0);
    chk("rst_active", a_if.active, 1'b1);
    chk("rst_frame_tick", a_if.frame_tick, 1'b0);
    chk("rst_vga_r", a_if.vga_r, 4'h0);
    chk("rst_vga_g", a_if.vga_g, 4'h0);
    chk("rst_vga_b", a_if.vga_b, 4'h0);
    chk("rst_vga_hs", a_if.vga_hs, 1'b1);
    chk("rst_vga_vs", a_if.vga_vs, 1'b0);
    chk("rst_b_vga_vs", b_if.vga_vs, 1'b0);
    chk("rst_b_vga_r", b_if.vga_r, 4'h0);

    rst_n  = 1'b1;
    pa_pix = 12'h006;
    pa_act = 1'b1;
    {a_if.pix_r, a_if.pix_g, a_if.pix_b} = pa_pix;
    chk("release_draw_x", a_if.draw_x, 11'd0);

    for (int unsigned c = 1; c <= 3808; c++) begin
      @(negedge clk);
      ax     = c % 1904;
      ay     = c / 1904;
      a_act  = (ax < 1440) && (ay < 900);
      pax    = (c - 1) % 1904;
      exp_hs = !((pax >= 1520) && (pax < 1672));
      if (a_if.draw_x !== 11'(ax) || a_if.draw_y !== 10'(ay)) mis_a_xy++;
      if (a_if.active !== a_act || a_if.frame_tick !== 1'b0) mis_a_act++;
      if ({a_if.vga_r, a_if.vga_g, a_if.vga_b} !== (pa_act ? pa_pix : 12'h000)) mis_a_rgb++;
      if (a_if.vga_hs !== exp_hs || a_if.vga_vs !== 1'b0) mis_a_sync++;
      if (c <= 1904 && a_if.vga_hs === 1'b0) hs_low0++;

      if (c == 5)    chk("t1_count5", a_if.draw_x, 11'd5);
      if (c == 1903) chk("t1_x_last", a_if.draw_x, 11'd1903);
      if (c == 1904) begin
        chk("t1_wrap_x", a_if.draw_x, 11'd0);
        chk("t1_wrap_y", a_if.draw_y, 10'd1);
      end
      if (c == 1439) chk("active_last", a_if.active, 1'b1);
      if (c == 1440) begin
        chk("active_end", a_if.active, 1'b0);
        chk("rgb_last_pixel", {a_if.vga_r, a_if.vga_g, a_if.vga_b}, 12'h001);
      end
      if (c == 1441) chk("blank_overrides_pix", {a_if.vga_r, a_if.vga_g, a_if.vga_b}, 12'h000);
      if (c == 1520) chk("hs_before", a_if.vga_hs, 1'b1);
      if (c == 1521) chk("hs_first_low", a_if.vga_hs, 1'b0);
      if (c == 1672) chk("hs_last_low", a_if.vga_hs, 1'b0);
      if (c == 1673) chk("hs_after", a_if.vga_hs, 1'b1);

      bx     = c % 32;
      by     = (c / 32) % 18;
      bpx    = (c - 1) % 32;
      bpy    = ((c - 1) / 32) % 18;
      b_pact = (bpx < 16) && (bpy < 10);
      b_ehs  = !((bpx >= 20) && (bpx < 26));
      b_evs  = (bpy >= 12) && (bpy < 15);
      b_eft  = (bx == 0) && (by == 10);
      if (b_if.draw_x !== 11'(bx) || b_if.draw_y !== 10'(by)) mis_b++;
      if (b_if.vga_hs !== b_ehs || b_if.vga_vs !== b_evs) mis_b++;
      if (b_if.frame_tick !== b_eft) mis_b++;
      if ({b_if.vga_r, b_if.vga_g, b_if.vga_b} !== (b_pact ? 12'hFFF : 12'h000)) mis_b++;
      if (c <= 576) begin
        if (b_if.vga_vs === 1'b1) begin
          b_vs_hi0++;
          if (b_vs_first == 0) b_vs_first = c;
        end
        if (b_if.vga_r === 4'hF) b_on0++;
      end
      if (c <= 1728 && b_if.frame_tick === 1'b1) begin
        ft_cnt++;
        if (ft_first == 0) ft_first = c;
      end
      if (c == 575) begin
        chk("b_frame_last_x", b_if.draw_x, 11'd31);
        chk("b_frame_last_y", b_if.draw_y, 10'd17);
      end
      if (c == 576) begin
        chk("b_frame_wrap_x", b_if.draw_x, 11'd0);
        chk("b_frame_wrap_y", b_if.draw_y, 10'd0);
      end
      if (c == 320) chk("b_tick_on", b_if.frame_tick, 1'b1);
      if (c == 321) chk("b_tick_off", b_if.frame_tick, 1'b0);

      pa_pix = (ax >= 1440) ? 12'hFFF : 12'(c * 37 + 6);
      pa_act = a_act;
      {a_if.pix_r, a_if.pix_g, a_if.pix_b} = pa_pix;
    end

    chk("a_xy_sequence", mis_a_xy, 0);
    chk("a_active_tick", mis_a_act, 0);
    chk("a_rgb_lag_blank", mis_a_rgb, 0);
    chk("a_sync_pins", mis_a_sync, 0);
    chk("t2_hs_low_count", hs_low0, 152);
    chk("b_model", mis_b, 0);
    chk("t3_vs_high_count", b_vs_hi0, 96);
    chk("t3_vs_first", b_vs_first, 385);
    chk("t4_on_count", b_on0, 160);
    chk("t5_tick_count", ft_cnt, 3);
    chk("t5_tick_first", ft_first, 320);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    {a_if.pix_r, a_if.pix_g, a_if.pix_b} = 12'h359;
    a_if.pat_sel = 1'b1;
    for (int unsigned c = 1; c <= 1600; c++) begin
      @(negedge clk);
      if (c == 360) chk("t6_at_x360", a_if.draw_x, 11'd360);
      if (c == 361) begin
`ifdef TEST_PATTERN_EN
        chk("t6_bar_r", a_if.vga_r, 4'h0);
        chk("t6_bar_g", a_if.vga_g, 4'hF);
        chk("t6_bar_b", a_if.vga_b, 4'h0);
`else
        chk("patsel_ignored_r", a_if.vga_r, 4'h3);
        chk("patsel_ignored_g", a_if.vga_g, 4'h5);
        chk("patsel_ignored_b", a_if.vga_b, 4'h9);
`endif
      end
    end
    chk("mid_hs_in_pulse", a_if.vga_hs, 1'b0);
    chk("mid_b_vs_in_pulse", b_if.vga_vs, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_draw_x", a_if.draw_x, 11'd0);
    chk("mid_rst_draw_y", a_if.draw_y, 10'd0);
    chk("mid_rst_active", a_if.active, 1'b1);
    chk("mid_rst_hs", a_if.vga_hs, 1'b1);
    chk("mid_rst_b_vs", b_if.vga_vs, 1'b0);
    chk("mid_rst_b_draw_y", b_if.draw_y, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;

    done = 1'b1;
    if (n_err != 0) $error("FAIL summary: %0d of %0d checks failed", n_err, n_checks);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
